// File: rtl/segment_transition_ctl.sv
// ---------------------------------------------------------------------------
// segment_transition_ctl
//
// Purpose:
//   Controls which of two waveform segments (0/1) is active in a sequencer.
//   A host issues an UPDATE pulse that either reloads the repetition count
//   of the active segment or requests a switch to the other segment. The
//   switch waits for a trigger:
//     - the next loop end (SYNC_IDX),
//     - the system time reaching a target (SYS_TIME),
//     - a rising edge on a selected GPIO pin (GPIO).
//   EXT mode ping-pongs between the segments at every loop end.
//   Finite repetition counts stop the sequence once they run out.
//
//   A loop end is a cycle with step_i=1 and idx_i==cycle_i.
//
// Handshake: update_i is a single-cycle strobe with no back-pressure. It is
//   sampled on the rising clock edge. An update always wins over any loop
//   end or trigger that occurs in the same cycle.
//
// Ports:
//   clk_i               clock, all state updates on the rising edge
//   rst_n_i             asynchronous active-low reset
//   update_i            one-cycle pulse that latches the request fields
//   req_segment_i       requested segment
//   transition_mode_i   0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
//   transition_value_i  target time (SYS_TIME) or pin select [1:0] (GPIO)
//   rep_i               extra loop count, 0xFFFF = infinite
//   idx_i               active sequencer index
//   cycle_i             last index of the active segment
//   step_i              sequencer advance strobe
//   sys_time_i          synchronized system time
//   gpio_in_i           external trigger inputs
//   segment_o           active segment
//   segment_switch_o    one-cycle pulse coinciding with a segment change
//   stop_o              finite repetitions exhausted
//   busy_o              waiting for a switch trigger
//   state_o             debug view of the FSM state
//                       (0 RUN, 1 WAIT, 2 STOPPED, 3 EXT)
//
// Configuration:
//   SEGMENT_TRANSITION_GPIO_SYNC_EN
//     When defined, gpio_in_i first passes through a 2-flop synchronizer.
//     This adds 2 cycles of latency before edge detection.
// ---------------------------------------------------------------------------
module segment_transition_ctl #(
    parameter int IDX_WIDTH = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 update_i,
    input  logic                 req_segment_i,
    input  logic [7:0]           transition_mode_i,
    input  logic [63:0]          transition_value_i,
    input  logic [15:0]          rep_i,
    input  logic [IDX_WIDTH-1:0] idx_i,
    input  logic [IDX_WIDTH-1:0] cycle_i,
    input  logic                 step_i,
    input  logic [63:0]          sys_time_i,
    input  logic [3:0]           gpio_in_i,
    output logic                 segment_o,
    output logic                 segment_switch_o,
    output logic                 stop_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STOPPED = 2'd2,
        ST_EXT     = 2'd3
    } state_e;

    localparam logic [7:0]  MODE_SYNC_IDX = 8'h00;
    localparam logic [7:0]  MODE_SYS_TIME = 8'h01;
    localparam logic [7:0]  MODE_GPIO     = 8'h02;
    localparam logic [7:0]  MODE_EXT      = 8'hF0;
    localparam logic [15:0] REP_INF       = 16'hFFFF;

    // Pending request modes are stored in 2 bits.
    // They reuse the low bits of the mode code.
    localparam logic [1:0]  PEND_SYNC_IDX = 2'd0;
    localparam logic [1:0]  PEND_SYS_TIME = 2'd1;
    localparam logic [1:0]  PEND_GPIO     = 2'd2;

    state_e      state_q, state_d;
    logic        seg_q, seg_d;
    logic        switch_q, switch_d;
    logic        stop_q, stop_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_seg_q, pend_seg_d;
    logic [1:0]  pend_mode_q, pend_mode_d;
    logic [63:0] pend_value_q, pend_value_d;
    logic [15:0] pend_rep_q, pend_rep_d;
    logic [3:0]  gpio_prev_q;
    logic [3:0]  gpio_s;
    logic [3:0]  gpio_rise;
    logic        loop_end;
    logic        mode_valid;
    logic        wait_trigger;

    // ------------------------------------------------------------------
    // GPIO path: optional synchronizer, then edge detection.
    // The edge is detected against the previous registered level.
    // ------------------------------------------------------------------
`ifdef SEGMENT_TRANSITION_GPIO_SYNC_EN
    logic [3:0] gpio_sync1_q, gpio_sync2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gpio_sync1_q <= 4'b0;
            gpio_sync2_q <= 4'b0;
        end else begin
            gpio_sync1_q <= gpio_in_i;
            gpio_sync2_q <= gpio_sync1_q;
        end
    end

    assign gpio_s = gpio_sync2_q;
`else
    assign gpio_s = gpio_in_i;
`endif

    assign gpio_rise  = gpio_s & ~gpio_prev_q;
    assign loop_end   = step_i && (idx_i == cycle_i);
    assign mode_valid = (transition_mode_i == MODE_SYNC_IDX) ||
                        (transition_mode_i == MODE_SYS_TIME) ||
                        (transition_mode_i == MODE_GPIO)     ||
                        (transition_mode_i == MODE_EXT);

    always_comb begin
        case (pend_mode_q)
            PEND_SYNC_IDX: wait_trigger = loop_end;
            PEND_SYS_TIME: wait_trigger = (sys_time_i >= pend_value_q);
            PEND_GPIO:     wait_trigger = gpio_rise[pend_value_q[1:0]];
            default:       wait_trigger = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_RUN;
            seg_q        <= 1'b0;
            switch_q     <= 1'b0;
            stop_q       <= 1'b0;
            cnt_q        <= REP_INF;
            pend_seg_q   <= 1'b0;
            pend_mode_q  <= PEND_SYNC_IDX;
            pend_value_q <= 64'd0;
            pend_rep_q   <= 16'd0;
            gpio_prev_q  <= 4'b0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            switch_q     <= switch_d;
            stop_q       <= stop_d;
            cnt_q        <= cnt_d;
            pend_seg_q   <= pend_seg_d;
            pend_mode_q  <= pend_mode_d;
            pend_value_q <= pend_value_d;
            pend_rep_q   <= pend_rep_d;
            gpio_prev_q  <= gpio_s;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. A valid update preempts everything else.
    // The loop end or trigger in the same cycle is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        seg_d        = seg_q;
        switch_d     = 1'b0;
        stop_d       = stop_q;
        cnt_d        = cnt_q;
        pend_seg_d   = pend_seg_q;
        pend_mode_d  = pend_mode_q;
        pend_value_d = pend_value_q;
        pend_rep_d   = pend_rep_q;

        if (update_i && mode_valid) begin
            stop_d = 1'b0;
            if (transition_mode_i == MODE_EXT) begin
                state_d = ST_EXT;
            end else if (req_segment_i == seg_q) begin
                state_d = ST_RUN;
                cnt_d   = rep_i;
            end else begin
                state_d      = ST_WAIT;
                pend_seg_d   = req_segment_i;
                pend_mode_d  = transition_mode_i[1:0];
                pend_value_d = transition_value_i;
                pend_rep_d   = rep_i;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    // An infinite count holds across loop ends.
                    if (loop_end && (cnt_q != REP_INF)) begin
                        if (cnt_q == 16'd0) begin
                            stop_d  = 1'b1;
                            state_d = ST_STOPPED;
                        end else begin
                            cnt_d = cnt_q - 16'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_trigger) begin
                        seg_d    = pend_seg_q;
                        switch_d = 1'b1;
                        cnt_d    = pend_rep_q;
                        stop_d   = 1'b0;
                        state_d  = ST_RUN;
                    end
                end
                ST_STOPPED: begin
                    state_d = ST_STOPPED;
                end
                ST_EXT: begin
                    if (loop_end) begin
                        seg_d    = ~seg_q;
                        switch_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all taken directly from registers.
    // ------------------------------------------------------------------
    always_comb begin
        segment_o        = seg_q;
        segment_switch_o = switch_q;
        stop_o           = stop_q;
        busy_o           = (state_q == ST_WAIT);
        state_o          = state_q;
    end

endmodule

// File: tb/tb_segment_transition_ctl.sv
module tb_segment_transition_ctl;

  localparam int IW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          update = 1'b0;
  logic          req_seg = 1'b0;
  logic [7:0]    mode = 8'h00;
  logic [63:0]   value = 64'd0;
  logic [15:0]   rep = 16'd0;
  logic [IW-1:0] idx = '0;
  logic [IW-1:0] cycle = '0;
  logic          step = 1'b0;
  logic [63:0]   sys_time = 64'd0;
  logic [3:0]    gpio = 4'b0;
  logic          segment_o, segment_switch_o, stop_o, busy_o;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  segment_transition_ctl #(.IDX_WIDTH(IW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .update_i(update), .req_segment_i(req_seg),
    .transition_mode_i(mode), .transition_value_i(value), .rep_i(rep),
    .idx_i(idx), .cycle_i(cycle), .step_i(step), .sys_time_i(sys_time),
    .gpio_in_i(gpio), .segment_o(segment_o), .segment_switch_o(segment_switch_o),
    .stop_o(stop_o), .busy_o(busy_o), .state_o(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_RUN, M_WAIT, M_STOPPED, M_EXT} mstate_e;
  mstate_e     m_st;
  int          m_seg, m_switch, m_stop, m_left, m_pseg, m_pmode, m_prep;
  logic [63:0] m_pval;
  logic [3:0]  hist [3];  // hist[k] = gpio sampled k+1 edges ago

  task automatic model_reset();
    m_st = M_RUN; m_seg = 0; m_switch = 0; m_stop = 0; m_left = 65535;
    m_pseg = 0; m_pmode = 0; m_prep = 0; m_pval = 64'd0;
    for (int k = 0; k < 3; k++) hist[k] = 4'b0;
  endtask

  task automatic model_step();
    logic le, e, trig;
    int pin;
    if (!rst_n) begin
      model_reset();
      return;
    end
    le  = step && (idx == cycle);
    pin = int'(m_pval[1:0]);
`ifdef SEGMENT_TRANSITION_GPIO_SYNC_EN
    e = hist[1][pin] && !hist[2][pin];
`else
    e = gpio[pin] && !hist[0][pin];
`endif
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = gpio;
    m_switch = 0;
    if (update && (mode inside {8'h00, 8'h01, 8'h02, 8'hF0})) begin
      m_stop = 0;
      if (mode == 8'hF0) m_st = M_EXT;
      else if (int'(req_seg) == m_seg) begin
        m_st = M_RUN; m_left = int'(rep);
      end else begin
        m_st = M_WAIT; m_pseg = int'(req_seg); m_pmode = int'(mode);
        m_pval = value; m_prep = int'(rep);
      end
    end else if (m_st == M_RUN && le) begin
      if (m_left == 0) begin
        m_stop = 1; m_st = M_STOPPED;
      end else if (m_left != 65535) begin
        m_left = m_left - 1;
      end
    end else if (m_st == M_WAIT) begin
      trig = (m_pmode == 0 && le) || (m_pmode == 1 && sys_time >= m_pval) ||
             (m_pmode == 2 && e);
      if (trig) begin
        m_seg = m_pseg; m_switch = 1; m_left = m_prep; m_stop = 0; m_st = M_RUN;
      end
    end else if (m_st == M_EXT && le) begin
      m_seg = 1 - m_seg; m_switch = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("segment", 64'(segment_o), 64'(m_seg));
    check_val("segment_switch", 64'(segment_switch_o), 64'(m_switch));
    check_val("stop", 64'(stop_o), 64'(m_stop));
    check_val("busy", 64'(busy_o), 64'(m_st == M_WAIT));
  endtask

  // ---------------- driver ----------------
  // One clock: model steps on the inputs the DUT samples, outputs are
  // compared on the falling edge, then the sequencer/time advance.
  task automatic cycle_once();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    if (step) idx = (idx == cycle) ? '0 : idx + 1'b1;
    sys_time = sys_time + 64'd1;
    update = 1'b0;
  endtask

  task automatic do_update(input logic rs, input logic [7:0] md,
                           input logic [63:0] val, input logic [15:0] rp);
    update = 1'b1; req_seg = rs; mode = md; value = val; rep = rp;
  endtask

  task automatic run(input int n, input logic stp);
    for (int i = 0; i < n; i++) begin
      step = stp;
      cycle_once();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    run(3, 1'b0);
    check_val("reset_state", 64'(state_dbg), 64'd0);
    check_val("reset_seg", 64'(segment_o), 64'd0);
    rst_n = 1'b1;

    // SYNC_IDX switch at the loop end with cycle=9
    cycle = 15'd9; idx = '0;
    do_update(1'b1, 8'h00, 64'd0, 16'hFFFF);
    run(1, 1'b0);
    check_val("sync_busy", 64'(busy_o), 64'd1);
    run(12, 1'b1);
    check_val("sync_seg", 64'(segment_o), 64'd1);

    // REP=2 on a switch to segment 0, then stop on the 3rd loop end
    cycle = 15'd2; idx = '0;
    do_update(1'b0, 8'h00, 64'd0, 16'd2);
    run(20, 1'b1);
    check_val("rep_stop", 64'(stop_o), 64'd1);
    check_val("rep_seg", 64'(segment_o), 64'd0);

    // SYS_TIME ramp 990.. with target 1000
    sys_time = 64'd990;
    do_update(1'b1, 8'h01, 64'd1000, 16'hFFFF);
    run(22, 1'b0);
    check_val("time_seg", 64'(segment_o), 64'd1);

    // GPIO pin 2; edges on other pins must not switch
    gpio = 4'b0;
    do_update(1'b0, 8'h02, 64'd2, 16'hFFFF);
    run(3, 1'b0);
    gpio = 4'b1011;
    run(5, 1'b0);
    check_val("gpio_other_pins", 64'(busy_o), 64'd1);
    gpio = 4'b1111;
    run(5, 1'b0);
    check_val("gpio_seg", 64'(segment_o), 64'd0);
    gpio = 4'b0;

    // EXT ping-pong, then an update coinciding with a loop end
    cycle = 15'd1; idx = '0;
    do_update(1'b0, 8'hF0, 64'd0, 16'd0);
    run(9, 1'b1);
    while (idx != cycle) run(1, 1'b1);
    do_update(1'b0, 8'hF0, 64'd0, 16'd0);
    run(4, 1'b1);

    // Reset asserted while a request is pending
    do_update(m_seg == 0, 8'h00, 64'd0, 16'hFFFF);
    run(1, 1'b0);
    check_val("wait_busy", 64'(busy_o), 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_wait_busy", 64'(busy_o), 64'd0);
    check_val("rst_wait_switch", 64'(segment_switch_o), 64'd0);
    check_val("rst_wait_stop", 64'(stop_o), 64'd0);
    @(negedge clk);
    run(2, 1'b0);
    rst_n = 1'b1;
    run(2, 1'b1);

    // Randomized traffic
    cycle = 15'd3; idx = '0;
    for (int i = 0; i < 4000; i++) begin
      step = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) gpio[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        cycle = IW'($urandom_range(0, 5)); idx = '0;
      end
      if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      if ($urandom_range(0, 14) == 0) begin
        update = 1'b1;
        req_seg = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0: mode = 8'h00;
          1: mode = 8'h01;
          2: mode = 8'h02;
          3: mode = 8'hF0;
          default: mode = 8'($urandom_range(3, 200));
        endcase
        if (mode == 8'h01) value = sys_time + 64'($urandom_range(0, 30)) - 64'd5;
        else value = {$urandom, $urandom};
        case ($urandom_range(0, 4))
          0: rep = 16'd0;
          1: rep = 16'd1;
          2: rep = 16'd2;
          3: rep = 16'($urandom_range(3, 6));
          default: rep = 16'hFFFF;
        endcase
      end
      cycle_once();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/segment_transition_ctl.md
SEGMENT_TRANSITION_CTL -- requirements
Module: segment_transition_ctl

Interface
REQ-001 Parameter IDX_WIDTH, default 15, SHALL set the width of the sequencer index and cycle ports.
REQ-002 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 RST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 UPDATE  in  1  SHALL be a one-cycle pulse that latches REQ_SEGMENT, TRANSITION_MODE, TRANSITION_VALUE and REP.
REQ-005 REQ_SEGMENT  in  1  SHALL be the requested segment (0/1).
REQ-006 TRANSITION_MODE  in  8  SHALL select the mode: 0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT.
REQ-007 TRANSITION_VALUE  in  64  SHALL be the target system time (SYS_TIME) or the GPIO pin select in bits [1:0] (GPIO).
REQ-008 REP  in  16  SHALL be the extra loop count for the new segment; 0xFFFF SHALL mean infinite.
REQ-009 IDX  in  IDX_WIDTH  SHALL be the active sequencer index.
REQ-010 CYCLE  in  IDX_WIDTH  SHALL be the last index of the active segment.
REQ-011 STEP  in  1  SHALL pulse when the sequencer advances IDX; a loop end SHALL be STEP=1 with IDX==CYCLE.
REQ-012 SYS_TIME  in  64  SHALL be the synchronized system time.
REQ-013 GPIO_IN  in  4  SHALL be the external trigger inputs.
REQ-014 SEGMENT  out  1  SHALL be the active segment.
REQ-015 SEGMENT_SWITCH  out  1  SHALL pulse for one cycle, in the same cycle that SEGMENT changes.
REQ-016 STOP  out  1  SHALL be 1 when the finite repetitions are exhausted.
REQ-017 BUSY  out  1  SHALL be 1 while in WAIT.

Function
REQ-018 The block SHALL use the states RUN, WAIT, STOPPED and EXT.
REQ-019 On UPDATE with REQ_SEGMENT==SEGMENT and mode!=EXT, the block SHALL reload the repetition counter from REP, clear STOP and enter RUN without a switch.
REQ-020 On UPDATE with REQ_SEGMENT!=SEGMENT and a valid non-EXT mode, the block SHALL enter WAIT with the registered inputs; BUSY SHALL be 1 from the next cycle.
REQ-021 In WAIT with SYNC_IDX, the block SHALL switch on the next loop end.
REQ-022 In WAIT with SYS_TIME, the block SHALL switch on the first cycle with SYS_TIME >= the latched value (unsigned compare); a past time SHALL switch on the first WAIT cycle.
REQ-023 In WAIT with GPIO, the block SHALL switch on a rising edge of GPIO_IN[value[1:0]] detected against the previous registered level.
REQ-024 On switch, the block SHALL set SEGMENT to the requested segment, pulse SEGMENT_SWITCH, load the counter from REP, clear STOP and enter RUN.
REQ-025 In RUN, at each loop end: counter 0xFFFF SHALL hold; counter 0 SHALL assert STOP and enter STOPPED; otherwise the counter SHALL decrement by 1.
REQ-026 In STOPPED, STOP SHALL remain 1 and loop ends SHALL be ignored until UPDATE.
REQ-027 On UPDATE with mode EXT, the block SHALL enter EXT, toggle SEGMENT at every loop end with a SEGMENT_SWITCH pulse, and assert STOP never.
REQ-028 An UPDATE with an undefined mode SHALL be ignored with no state change.
REQ-029 UPDATE in any state, including WAIT, SHALL preempt the state; the pending request SHALL be discarded.
REQ-030 When UPDATE and a loop end coincide, UPDATE SHALL win and the loop end SHALL be neither counted nor used for a switch.
REQ-031 Latency from the trigger condition to the SEGMENT change SHALL be 1 cycle (registered outputs).

Reset
REQ-032 While RST_N=0, the block SHALL hold state RUN, counter 0xFFFF, SEGMENT=0, SEGMENT_SWITCH=0, STOP=0, BUSY=0 and the GPIO history at 0.
REQ-033 Reset asserted mid-WAIT SHALL discard the pending request with no switch pulse.

Configuration
REQ-034 With SEGMENT_TRANSITION_GPIO_SYNC_EN defined, GPIO_IN SHALL pass through a 2-flop synchronizer before edge detection, adding 2 cycles of latency.
REQ-035 Without SEGMENT_TRANSITION_GPIO_SYNC_EN, edge detection SHALL operate directly on GPIO_IN.

Verification
REQ-036 SYNC_IDX: SEGMENT=0, UPDATE(req 1, REP 0xFFFF), CYCLE=9 -> SEGMENT=1 with one SEGMENT_SWITCH pulse in the cycle after STEP with IDX=9.
REQ-037 SYS_TIME: value 1000, SYS_TIME ramps 990..1010 -> BUSY=1 until the switch, switch in the cycle after SYS_TIME=1000, BUSY=0 after.
REQ-038 GPIO: pin 2, rising edge on GPIO_IN[2] -> switch 1 cycle later (3 cycles with the macro defined); edges on other pins -> no switch.
REQ-039 REP=2: the 3rd loop end after the switch -> STOP=1; further loop ends leave SEGMENT and STOP unchanged.
REQ-040 EXT mode with 4 loop ends -> SEGMENT sequence 1,0,1,0 with 4 pulses; an UPDATE coinciding with a loop end -> no toggle.
REQ-041 RST_N dropped during WAIT -> all outputs 0 immediately, no SEGMENT_SWITCH pulse.
